wave_counter: RTL and testbench
===============================

WAVE_COUNTER -- requirements
Module: wave_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the phase counter width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset (rst=0 resets).
REQ-004 SHALL have port en, input, 1 bit: count enable.
REQ-005 SHALL have port clr, input, 1 bit: synchronous clear.
REQ-006 SHALL have port div, input, 8 bits: prescaler compare value; a tick occurs every div+1 enabled cycles.
REQ-007 SHALL have port step, input, WIDTH bits: phase increment applied per tick.
REQ-008 SHALL have port mode, input, 1 bit: 0 = wrap (sawtooth), 1 = up/down (triangle); used only with the configuration macro.
REQ-009 SHALL have port counter, output, WIDTH bits, registered: phase value fed to the square/waveform shaping stage.
REQ-010 SHALL have port wrap, output, 1 bit, registered: one-cycle period-boundary pulse.
REQ-011 SHALL have port dir, output, 1 bit, registered: current count direction (0 = up, 1 = down).

Function
REQ-012 SHALL keep an internal 8-bit prescaler pre_cnt; a tick is asserted in a cycle when en=1 and pre_cnt >= div.
REQ-013 On a tick, pre_cnt SHALL load 0; otherwise, when en=1, it SHALL increment by 1.
REQ-014 With div=0, the block SHALL tick every enabled cycle; with div=255, it SHALL tick once every 256 enabled cycles.
REQ-015 The block SHALL sample div every cycle; if div is lowered below pre_cnt, the next enabled cycle SHALL tick (no 256-cycle stall).
REQ-016 In wrap mode, a tick SHALL set counter to (counter + step) mod 2^WIDTH.
REQ-017 In wrap mode, wrap SHALL be 1 in the cycle after a tick whose addition carries out of WIDTH bits, and 0 otherwise.
REQ-018 With step=0, counter SHALL hold and wrap SHALL stay 0, while the prescaler keeps running.
REQ-019 With en=0, pre_cnt SHALL clear to 0, counter and dir SHALL hold, and wrap SHALL be 0.
REQ-020 With clr=1, pre_cnt, counter, wrap and dir SHALL be set to 0 on the next edge, taking priority over en and any tick.
REQ-021 Output latency SHALL be one clock from tick qualification to the updated counter/wrap; no combinational path from inputs to outputs.
REQ-022 A change of step mid-period SHALL take effect on the next tick only.

Reset
REQ-023 When rst=0, the block SHALL immediately (asynchronously) set pre_cnt=0, counter=0, wrap=0 and dir=0.
REQ-024 A reset asserted mid-period SHALL discard partial prescaler progress.
REQ-025 The first tick after rst deasserts SHALL occur div+1 enabled cycles after deassertion.

Configuration
REQ-026 Macro WAVE_COUNTER_UPDOWN_EN SHALL compile in triangle (up/down) mode support.
REQ-027 With the macro defined and mode=1, a tick SHALL move counter by step in direction dir, computed without overflow.
REQ-028 In up/down mode, if the next value would exceed 2^WIDTH-1, counter SHALL saturate at 2^WIDTH-1 and dir SHALL become 1.
REQ-029 In up/down mode, if the next value would fall below 0, counter SHALL saturate at 0, dir SHALL become 0, and wrap SHALL pulse for one cycle.
REQ-030 A tick that lands exactly on a limit SHALL reverse dir, and wrap SHALL pulse only at the bottom limit.
REQ-031 A mode change SHALL take effect at the next tick; switching to mode=0 SHALL force dir=0.
REQ-032 Without the macro, mode SHALL be ignored, dir SHALL be tied to 0, and behaviour SHALL be wrap mode only.

Verification
REQ-033 rst=0 mid-count with counter=0x5A -> counter=0, wrap=0 and dir=0 without waiting for a clock edge.
REQ-034 WIDTH=8, div=0, step=1, en=1 for 256 cycles from reset -> counter steps 0x01..0xFF, then 0x00 with a single wrap pulse in the cycle counter shows 0x00.
REQ-035 div=3, step=0x40 -> counter advances every 4 cycles (0x40, 0x80, 0xC0, 0x00), with wrap on the 0x00 update only.
REQ-036 div=200, wait for pre_cnt=150, then set div=10 -> tick on the next enabled cycle; en=0 for 5 cycles -> counter holds and pre_cnt restarts from 0.
REQ-037 clr=1 and en=1 on the same edge as a carry-generating tick -> counter=0 and wrap=0.
REQ-038 With WAVE_COUNTER_UPDOWN_EN defined, mode=1, div=0, step=0x60 -> counter 0x60, 0xC0, 0xFF (dir=1), 0x9F, 0x3F, 0x00 (dir=0, wrap pulse), 0x60.

Source files
------------

// File: rtl/wave_counter_if.sv
// Control and status bundle for wave_counter: the master drives the prescaler/phase
// controls, the slave returns the registered phase, the wrap pulse and the direction.
interface wave_counter_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             clr;
  logic [7:0]       div;
  logic [WIDTH-1:0] step;
  logic             mode;
  logic [WIDTH-1:0] counter;
  logic             wrap;
  logic             dir;

  modport master (
    output en, clr, div, step, mode,
    input  counter, wrap, dir
  );

  modport slave (
    input  en, clr, div, step, mode,
    output counter, wrap, dir
  );
endinterface

// File: rtl/wave_counter.sv
// Prescaled phase accumulator for waveform shaping: sawtooth by default, and triangle
// (saturating up/down) mode when built with WAVE_COUNTER_UPDOWN_EN.
module wave_counter #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  wave_counter_if.slave   bus
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [7:0]       pre_q, pre_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             dir_q, dir_d;
  logic             tick;
  logic [WIDTH:0]   sum_up;

  // >= rather than == so that lowering div below the running count ticks at once
  assign tick   = bus.en && (pre_q >= bus.div);
  assign sum_up = {1'b0, cnt_q} + {1'b0, bus.step};

`ifndef WAVE_COUNTER_UPDOWN_EN
  logic unused_mode;
  assign unused_mode = bus.mode;
`endif

  always_comb begin
    pre_d  = pre_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    dir_d  = dir_q;
    if (bus.clr) begin
      pre_d = '0;
      cnt_d = '0;
      dir_d = 1'b0;
    end else if (!bus.en) begin
      pre_d = '0;
    end else if (!tick) begin
      pre_d = pre_q + 8'd1;
    end else begin
      pre_d = '0;
`ifdef WAVE_COUNTER_UPDOWN_EN
      if (bus.mode) begin
        if (!dir_q) begin
          if (sum_up >= {1'b0, CNT_MAX}) begin
            cnt_d = CNT_MAX;
            dir_d = 1'b1;
          end else begin
            cnt_d = sum_up[WIDTH-1:0];
          end
        end else if (bus.step >= cnt_q) begin
          cnt_d  = '0;
          dir_d  = 1'b0;
          wrap_d = 1'b1;
        end else begin
          cnt_d = cnt_q - bus.step;
        end
      end else begin
        cnt_d  = sum_up[WIDTH-1:0];
        wrap_d = sum_up[WIDTH];
        dir_d  = 1'b0;
      end
`else
      cnt_d  = sum_up[WIDTH-1:0];
      wrap_d = sum_up[WIDTH];
      dir_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q  <= '0;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      dir_q  <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      dir_q  <= dir_d;
    end
  end

  assign bus.counter = cnt_q;
  assign bus.wrap    = wrap_q;
  assign bus.dir     = dir_q;

endmodule

// File: tb/tb_wave_counter.sv
// Directed and randomized checks of wave_counter against an arithmetic reference model.
module tb_wave_counter;

  localparam int W   = 8;
  localparam int MOD = 1 << W;
  localparam int MAXV = MOD - 1;

  logic clk = 1'b0;
  logic rst;

  wave_counter_if #(.WIDTH(W)) bus ();
  wave_counter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_pre, m_cnt, m_wrap, m_dir;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pre = 0; m_cnt = 0; m_wrap = 0; m_dir = 0;
  endtask

  // One rising edge of the reference, from the inputs currently applied.
  task automatic model_edge();
    int s;
    if (bus.clr) begin
      m_pre = 0; m_cnt = 0; m_wrap = 0; m_dir = 0;
    end else if (!bus.en) begin
      m_pre = 0; m_wrap = 0;
    end else if (m_pre < int'(bus.div)) begin
      m_pre = m_pre + 1; m_wrap = 0;
    end else begin
      m_pre = 0;
`ifdef WAVE_COUNTER_UPDOWN_EN
      if (bus.mode) begin
        if (m_dir == 0) begin
          s = m_cnt + int'(bus.step);
          m_wrap = 0;
          if (s >= MAXV) begin m_cnt = MAXV; m_dir = 1; end
          else m_cnt = s;
        end else begin
          s = m_cnt - int'(bus.step);
          if (s <= 0) begin m_cnt = 0; m_dir = 0; m_wrap = 1; end
          else begin m_cnt = s; m_wrap = 0; end
        end
      end else begin
        s = m_cnt + int'(bus.step);
        m_wrap = (s >= MOD) ? 1 : 0;
        m_cnt = s % MOD;
        m_dir = 0;
      end
`else
      s = m_cnt + int'(bus.step);
      m_wrap = (s >= MOD) ? 1 : 0;
      m_cnt = s % MOD;
      m_dir = 0;
`endif
    end
  endtask

  task automatic cyc(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check({tag, "_cnt"},  int'(bus.counter), m_cnt);
    check({tag, "_wrap"}, int'(bus.wrap),    m_wrap);
    check({tag, "_dir"},  int'(bus.dir),     m_dir);
  endtask

  initial begin
    int prev;
    rst = 1'b0;
    bus.en = 1'b0; bus.clr = 1'b0; bus.div = 8'd0; bus.step = '0; bus.mode = 1'b0;
    model_reset();
    #12;
    check("reset_cnt",  int'(bus.counter), 0);
    check("reset_wrap", int'(bus.wrap),    0);
    check("reset_dir",  int'(bus.dir),     0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Full-rate sawtooth: 0x01..0xFF then 0x00 with one wrap pulse
    bus.en = 1'b1; bus.div = 8'd0; bus.step = 8'd1;
    for (int i = 0; i < 256; i++) begin
      cyc("saw1");
      if (i == 254) check("saw1_top", int'(bus.counter), 8'hFF);
    end
    check("saw1_end_cnt",  int'(bus.counter), 0);
    check("saw1_end_wrap", int'(bus.wrap),    1);

    // div=3: advance every 4 cycles in 0x40 steps
    bus.div = 8'd3; bus.step = 8'h40;
    for (int i = 0; i < 16; i++) begin
      cyc("div3");
      if (i == 3)  check("div3_first", int'(bus.counter), 8'h40);
      if (i == 15) check("div3_wrap",  int'(bus.wrap),    1);
    end

    // Asynchronous reset mid-period with counter at 0x5A
    bus.div = 8'd0; bus.step = 8'h5A;
    cyc("pre_rst");
    check("pre_rst_5a", int'(bus.counter), 8'h5A);
    bus.div = 8'd5;
    cyc("mid"); cyc("mid");
    #2 rst = 1'b0;
    #1;
    check("async_cnt",  int'(bus.counter), 0);
    check("async_wrap", int'(bus.wrap),    0);
    check("async_dir",  int'(bus.dir),     0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;

    // First tick div+1 enabled cycles after reset release
    bus.div = 8'd2; bus.step = 8'd1;
    cyc("first"); cyc("first");
    check("first_hold", int'(bus.counter), 0);
    cyc("first");
    check("first_tick", int'(bus.counter), 1);

    // Lowering div below the running prescaler ticks immediately
    bus.div = 8'd200;
    for (int i = 0; i < 150; i++) cyc("div200");
    prev = int'(bus.counter);
    bus.div = 8'd10;
    cyc("div_drop");
    check("div_drop_tick", int'(bus.counter), (prev + 1) % MOD);
    bus.en = 1'b0;
    for (int i = 0; i < 5; i++) cyc("en_off");
    bus.en = 1'b1; bus.div = 8'd3;
    for (int i = 0; i < 4; i++) cyc("restart");
    check("restart_tick", int'(bus.counter), (prev + 2) % MOD);

    // Clear wins over a carry-generating tick
    bus.clr = 1'b1; cyc("clr0"); bus.clr = 1'b0;
    bus.div = 8'd0; bus.step = 8'hF0;
    cyc("clr_setup");
    bus.clr = 1'b1;
    cyc("clr_carry");
    check("clr_carry_cnt",  int'(bus.counter), 0);
    check("clr_carry_wrap", int'(bus.wrap),    0);
    bus.clr = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bus.en   = ($urandom % 8) != 0;
      bus.clr  = ($urandom % 40) == 0;
      bus.div  = (($urandom % 16) == 0) ? 8'($urandom) : 8'($urandom % 5);
      bus.step = (($urandom % 10) == 0) ? '0 : W'($urandom);
      bus.mode = ($urandom % 2) != 0;
      cyc("rand");
    end
    bus.mode = 1'b0;

`ifdef WAVE_COUNTER_UPDOWN_EN
    begin
      int exp_c[7] = '{8'h60, 8'hC0, 8'hFF, 8'h9F, 8'h3F, 8'h00, 8'h60};
      int exp_d[7] = '{0, 0, 1, 1, 1, 0, 0};
      int exp_w[7] = '{0, 0, 0, 0, 0, 1, 0};
      bus.en = 1'b1; bus.clr = 1'b1; cyc("tri_clr"); bus.clr = 1'b0;
      bus.mode = 1'b1; bus.div = 8'd0; bus.step = 8'h60;
      for (int i = 0; i < 7; i++) begin
        cyc("tri");
        check("tri_lit_cnt",  int'(bus.counter), exp_c[i]);
        check("tri_lit_dir",  int'(bus.dir),     exp_d[i]);
        check("tri_lit_wrap", int'(bus.wrap),    exp_w[i]);
      end
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
